// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_state_e : control FSM states (IDLE, MULT, DIV, DONE)
//   MDU_DATA_W  : default operand width, also the width of each of HI and LO
//   MDU_CNT_W   : default iteration counter width (>= clog2(DATA_W)+1)
package mult_div_unit_pkg;

  localparam int unsigned MDU_DATA_W = 32;
  localparam int unsigned MDU_CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to sign-correct results.
//   val_i : input value
//   neg_i : 1 = output -val_i, 0 = output val_i unchanged
//   res_o : result
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed/unsigned multiply and divide, writer side
// of the HI/LO register pair. One operand bit is processed per cycle.
// Ports:
//   clk, reset_n          : clock (rising edge), asynchronous active-low reset
//   op_a, op_b            : multiplicand/dividend (rs), multiplier/divisor (rt)
//   start_mult, start_div : begin an operation; sampled only while idle
//   is_signed             : 1 = MULT/DIV, 0 = MULTU/DIVU; sampled with start
//   hi_data, lo_data      : product high/low, or remainder/quotient
//   hi_write, lo_write    : one-cycle write strobes (always together)
//   busy                  : operation in progress
//   div_zero              : one-cycle flag for a divide by zero (nothing runs)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W,
  parameter int unsigned CNT_W  = MDU_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic              is_signed,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  output logic              hi_write,
  output logic              lo_write,
  output logic              busy,
  output logic              div_zero
);

  mdu_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   b_mag_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic [DATA_W-1:0]   hi_data_q;
  logic [DATA_W-1:0]   lo_data_q;
  logic                hi_write_q;
  logic                lo_write_q;
  logic                busy_q;
  logic                div_zero_q;

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;

  logic [DATA_W:0]     mul_sum_d;
  logic [2*DATA_W-1:0] mul_acc_d;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W:0]     div_shift_d;
  logic [DATA_W-1:0]   div_diff_d;
  logic                div_ge;
  logic [DATA_W-1:0]   div_rem_d;
  logic [DATA_W-1:0]   div_quo_d;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic                last_iter;

  assign a_neg     = is_signed & op_a[DATA_W-1];
  assign b_neg     = is_signed & op_b[DATA_W-1];
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

  mdu_sign_fix #(.W(DATA_W)) u_a_mag (
    .val_i (op_a),
    .neg_i (a_neg),
    .res_o (a_mag)
  );

  mdu_sign_fix #(.W(DATA_W)) u_b_mag (
    .val_i (op_b),
    .neg_i (b_neg),
    .res_o (b_mag)
  );

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
  // Restoring divide: the DATA_W+1-bit shifted remainder is compared with the
  // divisor; the difference only needs DATA_W bits because a successful
  // subtraction always leaves a value below the divisor.
  always_comb begin
    mul_sum_d   = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + {1'b0, (acc_q[0] ? b_mag_q : {DATA_W{1'b0}})};
    mul_acc_d   = {mul_sum_d, acc_q[DATA_W-1:1]};
    div_shift_d = {rem_q, quo_q[DATA_W-1]};
    div_ge      = (div_shift_d >= {1'b0, b_mag_q});
    div_diff_d  = div_shift_d[DATA_W-1:0] - b_mag_q;
    div_rem_d   = div_ge ? div_diff_d : div_shift_d[DATA_W-1:0];
    div_quo_d   = {quo_q[DATA_W-2:0], div_ge};
  end

  // Result correction works on the final-iteration values so the corrected
  // result can be registered on the same edge that enters DONE.
  mdu_sign_fix #(.W(2*DATA_W)) u_prod_fix (
    .val_i (mul_acc_d),
    .neg_i (neg_res_q),
    .res_o (prod_fix)
  );

  mdu_sign_fix #(.W(DATA_W)) u_quo_fix (
    .val_i (div_quo_d),
    .neg_i (neg_res_q),
    .res_o (quo_fix)
  );

  mdu_sign_fix #(.W(DATA_W)) u_rem_fix (
    .val_i (div_rem_d),
    .neg_i (neg_rem_q),
    .res_o (rem_fix)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      b_mag_q    <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_data_q  <= '0;
      lo_data_q  <= '0;
      hi_write_q <= 1'b0;
      lo_write_q <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      hi_write_q <= 1'b0;
      lo_write_q <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_mult) begin
            state_q   <= ST_MULT;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= {{DATA_W{1'b0}}, a_mag};
            b_mag_q   <= b_mag;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
          end else if (start_div) begin
            if (op_b == '0) begin
              div_zero_q <= 1'b1;
            end else begin
              state_q   <= ST_DIV;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= a_mag;
              b_mag_q   <= b_mag;
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        ST_MULT: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q    <= ST_DONE;
            hi_data_q  <= prod_fix[2*DATA_W-1:DATA_W];
            lo_data_q  <= prod_fix[DATA_W-1:0];
            hi_write_q <= 1'b1;
            lo_write_q <= 1'b1;
          end
        end
        ST_DIV: begin
          rem_q <= div_rem_d;
          quo_q <= div_quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q    <= ST_DONE;
            hi_data_q  <= rem_fix;
            lo_data_q  <= quo_fix;
            hi_write_q <= 1'b1;
            lo_write_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_data  = hi_data_q;
  assign lo_data  = lo_data_q;
  assign hi_write = hi_write_q;
  assign lo_write = lo_write_q;
  assign busy     = busy_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random
// operations checked cycle by cycle against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start_mult;
  logic        start_div;
  logic        is_signed;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        div_zero;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] prev_hi  = '0;
  logic [31:0] prev_lo  = '0;

  mult_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_a       (op_a),
    .op_b       (op_b),
    .start_mult (start_mult),
    .start_div  (start_div),
    .is_signed  (is_signed),
    .hi_data    (hi_data),
    .lo_data    (lo_data),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .busy       (busy),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO}: product for multiply, {remainder, quotient} for divide.
  function automatic logic [63:0] model(input bit mul, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (mul) return sgn ? 64'(sa * sb) : 64'(ua * ub);
    if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
    end else begin
      sq = longint'(ua / ub);
      sr = longint'(ua % ub);
    end
    return {sr[31:0], sq[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the unit idle. Start is presented in cycle 0;
  // cycles 1..34 are checked. Returns at the negedge of cycle 34 (idle).
  // pulse_at: cycle in which both starts are pulsed while busy (0 = none).
  task automatic run_op(input bit mul, input bit dv, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input string tag);
    logic [63:0] exp;
    exp        = model(mul, sgn, a, b);
    op_a       = a;
    op_b       = b;
    start_mult = mul;
    start_div  = dv;
    is_signed  = sgn;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    is_signed  = 1'($urandom_range(0, 1));
    for (int c = 1; c <= 34; c++) begin
      chk($sformatf("%s c%0d busy", tag, c), busy, (c <= 33));
      chk($sformatf("%s c%0d hi_write", tag, c), hi_write, (c == 33));
      chk($sformatf("%s c%0d lo_write", tag, c), lo_write, (c == 33));
      chk($sformatf("%s c%0d div_zero", tag, c), div_zero, 1'b0);
      if (c == 33) begin
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
      end
      chk($sformatf("%s c%0d hi_data", tag, c), hi_data, prev_hi);
      chk($sformatf("%s c%0d lo_data", tag, c), lo_data, prev_lo);
      if (c < 34) begin
        start_div  = (c == pulse_at);
        start_mult = (c == pulse_at);
        @(negedge clk);
      end
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  task automatic run_div0(input logic [31:0] a, input bit sgn);
    op_a      = a;
    op_b      = '0;
    start_div = 1'b1;
    is_signed = sgn;
    @(negedge clk);
    start_div = 1'b0;
    chk("div0 c1 div_zero", div_zero, 1'b1);
    chk("div0 c1 busy", busy, 1'b0);
    chk("div0 c1 hi_write", hi_write, 1'b0);
    chk("div0 c1 lo_write", lo_write, 1'b0);
    chk("div0 c1 hi_data", hi_data, prev_hi);
    chk("div0 c1 lo_data", lo_data, prev_lo);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("div0 c%0d div_zero", c), div_zero, 1'b0);
      chk($sformatf("div0 c%0d busy", c), busy, 1'b0);
      chk($sformatf("div0 c%0d strobes", c), {hi_write, lo_write}, 2'b00);
      chk($sformatf("div0 c%0d hi_data", c), hi_data, prev_hi);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    op_a       = '0;
    op_b       = '0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    is_signed  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {hi_data, lo_data, hi_write, lo_write, busy, div_zero}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(1, 0, 1, 32'h0000_0007, 32'hFFFF_FFFD, 0, "mult_s_7x-3");
    run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_ff");
    run_op(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mult_s_ff");
    run_op(0, 1, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_s_-7/2");
    run_op(0, 1, 0, 32'd100, 32'd7, 0, "divu_100/7");
    run_div0(32'h1234_5678, 1'b1);
    run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, "mult_minmin");
    run_op(1, 1, 0, 32'd3, 32'd5, 10, "both_start");

    // Reset in cycle 10 of a multiply: outputs clear at once, no strobe.
    op_a       = 32'hFFFF_FFFF;
    op_b       = 32'h0001_2345;
    start_mult = 1'b1;
    is_signed  = 1'b0;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset outputs", {hi_data, lo_data, hi_write, lo_write, busy, div_zero}, '0);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("postreset c%0d busy/strobes", c), {busy, hi_write, lo_write}, 3'b000);
      @(negedge clk);
    end
    run_op(1, 0, 0, 32'd2, 32'd2, 0, "mult_2x2");

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      bit          m;
      bit          s;
      ra = pick();
      rb = pick();
      m  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      if (!m && rb == '0) rb = 32'h0000_0001;
      run_op(m, !m, s, ra, rb, 0, $sformatf("rand%0d_%s%s", i, m ? "mul" : "div", s ? "s" : "u"));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed/unsigned multiply and divide unit; it is the writer side of the HI/LO register pair.
- Takes two 32-bit operands from the datapath and iterates one bit per cycle.
- Drives result data plus one-cycle write strobes for HI and LO (MULT/MULTU/DIV/DIVU).
- The control FSM stalls on busy; MFHI/MFLO read from the HI/LO registers, not from this block.

Parameters:
DATA_W, 32, operand width and width of each of HI and LO
CNT_W, 6, iteration counter width; must be at least clog2(DATA_W)+1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
op_a  input  DATA_W  multiplicand / dividend (rs)
op_b  input  DATA_W  multiplier / divisor (rt)
start_mult  input  1  begin multiply; sampled only when idle
start_div  input  1  begin divide; sampled only when idle
is_signed  input  1  1 = MULT/DIV (two's complement), 0 = MULTU/DIVU; sampled with start
hi_data  output  DATA_W  value for HI: product[63:32] or remainder
lo_data  output  DATA_W  value for LO: product[31:0] or quotient
hi_write  output  1  one-cycle HI write strobe
lo_write  output  1  one-cycle LO write strobe
busy  output  1  operation in progress; control must not issue MFHI/MFLO/new start
div_zero  output  1  one-cycle flag: divide by zero detected

Behaviour:
- Reset: asynchronous on reset_n low. State returns to IDLE. hi_data, lo_data, hi_write, lo_write, busy and div_zero all read 0. Counter and internal registers clear.
- Reset mid-operation: the operation is abandoned with no write strobe.
- All outputs are registered.
- FSM states: IDLE, MULT, DIV, DONE.
- IDLE:
  - start_mult=1 -> MULT. This takes priority when start_mult and start_div are both 1.
  - start_div=1 with op_b!=0 -> DIV.
  - start_div=1 with op_b==0 -> stay in IDLE, div_zero=1 next cycle only, no hi_write/lo_write, busy stays 0.
  - On accept, latch operand magnitudes and result signs: negate an operand if is_signed and its bit 31 is 1. Clear the counter.
- Start held or pulsed while busy=1 is ignored; it is not queued.
- MULT: shift-add on 32-bit unsigned magnitudes, one multiplier bit per cycle, DATA_W cycles. 64-bit accumulator.
- DIV: restoring division on magnitudes, one quotient bit per cycle, DATA_W cycles. DATA_W+1-bit partial remainder.
- Counter increments each iteration cycle. On the last iteration (count == DATA_W-1), go to DONE.
- DONE, one cycle:
  - hi_data/lo_data hold the sign-corrected result; hi_write=lo_write=1; busy=1.
  - Then IDLE, busy=0, strobes 0.
  - hi_data/lo_data hold their last value until the next DONE.
- Sign rules (is_signed=1 only):
  - Product negated when op_a[31]^op_b[31].
  - Quotient negated when op_a[31]^op_b[31].
  - Remainder takes the sign of the dividend (truncation toward zero).
- Timing: start in cycle 0 -> busy=1 in cycles 1..33 -> strobes in cycle 33 -> busy=0 in cycle 34. A new start is accepted in cycle 34 (busy=0).
- Magnitude of -2^31 is 0x80000000, which is valid unsigned.
- Signed overflow case, DIV -2^31 / -1: lo=0x80000000, hi=0x00000000.
- hi_write and lo_write are always asserted together. Separate ports are kept for MTHI/MTLO muxing upstream.

Decomposition:
- Shared package: state enum (IDLE, MULT, DIV, DONE), DATA_W default, CNT_W default.
- Optional sub-module mdu_sign_fix: combinational conditional two's-complement negate, instantiated for operand magnitudes and result correction.
- The iteration datapath stays in mult_div_unit.

Test Plan:
- MULT, is_signed=1, a=7, b=0xFFFFFFFD (-3) -> cycle 33: hi_data=0xFFFFFFFF, lo_data=0xFFFFFFEB, hi_write=lo_write=1 for exactly one cycle; busy high cycles 1..33.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same op with is_signed=1 -> hi=0x00000000, lo=0x00000001.
- DIV, is_signed=1, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIV with b=0 -> div_zero=1 in cycle 1 only, busy stays 0, no strobes, hi/lo_data unchanged. Edge cases: DIV -2^31/-1 -> lo=0x80000000, hi=0.
- start_mult and start_div together (a=3, b=5) -> multiply runs, hi=0, lo=15. start_div pulsed in cycle 10 is ignored; exactly one strobe pair occurs.
- reset_n low in cycle 10 of a MULT -> all outputs 0 immediately, no strobe ever. After release, a new MULT 2×2 gives lo=4 at its cycle 33.
